// File: rtl/multi_hit_encoder.sv
// multi_hit_encoder: drains a hit vector as ascending binary indices, one per ready beat.
// Optional MULTI_HIT_ENCODER_EMPTY_FLAG_EN: an all-zero vector yields one empty_o beat.  Rev 1.0
`default_nettype none

module multi_hit_encoder #(
  parameter int CODE_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [(2**CODE_WIDTH)-1:0] vec_i,
  input  logic                       vec_valid_i,
  output logic                       vec_ready_o,
  output logic [CODE_WIDTH-1:0]      code_o,
  output logic                       code_valid_o,
  input  logic                       code_ready_i,
  output logic                       code_last_o
`ifdef MULTI_HIT_ENCODER_EMPTY_FLAG_EN
  ,
  output logic                       empty_o
`endif
);

  localparam int VEC_W = 2**CODE_WIDTH;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t                state_q;
  logic [VEC_W-1:0]      pend_q;
  logic [VEC_W-1:0]      pend_d;
  logic [CODE_WIDTH-1:0] code_q;
  logic                  last_q;
`ifdef MULTI_HIT_ENCODER_EMPTY_FLAG_EN
  logic                  empty_q;
`endif

  function automatic logic [CODE_WIDTH-1:0] lowest_idx(input logic [VEC_W-1:0] v);
    logic [CODE_WIDTH-1:0] idx;
    idx = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (v[i]) idx = i[CODE_WIDTH-1:0];
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

  // Pending set after this edge; a beat strips the lowest set bit.
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_IDLE) begin
      if (vec_valid_i) pend_d = vec_i;
    end else if (code_ready_i) begin
      pend_d = pend_q & (pend_q - VEC_W'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      last_q  <= 1'b0;
`ifdef MULTI_HIT_ENCODER_EMPTY_FLAG_EN
      empty_q <= 1'b0;
`endif
    end else begin
      pend_q <= pend_d;
      case (state_q)
        S_IDLE: begin
          if (vec_valid_i) begin
            if (vec_i != '0) begin
              state_q <= S_EMIT;
              code_q  <= lowest_idx(pend_d);
              last_q  <= single_bit(pend_d);
            end
`ifdef MULTI_HIT_ENCODER_EMPTY_FLAG_EN
            else begin
              state_q <= S_EMIT;
              code_q  <= '0;
              last_q  <= 1'b1;
              empty_q <= 1'b1;
            end
`endif
          end
        end
        S_EMIT: begin
          if (code_ready_i) begin
            code_q <= lowest_idx(pend_d);
            last_q <= single_bit(pend_d);
`ifdef MULTI_HIT_ENCODER_EMPTY_FLAG_EN
            empty_q <= 1'b0;
`endif
            if (last_q) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec_ready_o  = (state_q == S_IDLE);
  assign code_valid_o = (state_q == S_EMIT);
  assign code_o       = code_q;
  assign code_last_o  = last_q;
`ifdef MULTI_HIT_ENCODER_EMPTY_FLAG_EN
  assign empty_o      = empty_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_hit_encoder.sv
// Self-checking bench for multi_hit_encoder (CODE_WIDTH=4): vector table, directed corners, random.
`default_nettype none

module tb_multi_hit_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] vec_i = '0;
  logic        vec_valid_i = 1'b0;
  logic        vec_ready_o;
  logic [3:0]  code_o;
  logic        code_valid_o;
  logic        code_ready_i = 1'b0;
  logic        code_last_o;
`ifdef MULTI_HIT_ENCODER_EMPTY_FLAG_EN
  logic        empty_o;
`endif

  multi_hit_encoder #(.CODE_WIDTH(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .vec_i        (vec_i),
    .vec_valid_i  (vec_valid_i),
    .vec_ready_o  (vec_ready_o),
    .code_o       (code_o),
    .code_valid_o (code_valid_o),
    .code_ready_i (code_ready_i),
    .code_last_o  (code_last_o)
`ifdef MULTI_HIT_ENCODER_EMPTY_FLAG_EN
    ,
    .empty_o      (empty_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic cur_empty();
`ifdef MULTI_HIT_ENCODER_EMPTY_FLAG_EN
    return empty_o;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  int   got_code[$];
  logic got_last[$];
  logic got_empty[$];
  int   emit_cycles;

  // Collects every beat of one vector; expectations come from build_expected().
  task automatic run_vec(input logic [15:0] v, input bit rnd_ready);
    bit   done, stalled;
    logic [3:0] pc;
    logic pl, pe;
    got_code.delete(); got_last.delete(); got_empty.delete();
    emit_cycles = 0;
    check("idle_ready_before", {31'b0, vec_ready_o}, 32'd1);
    vec_i = v; vec_valid_i = 1'b1;
    code_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    done = 1'b0; stalled = 1'b0; pc = '0; pl = 1'b0; pe = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (!code_valid_o) break;
      emit_cycles++;
      check("emit_vec_ready_low", {31'b0, vec_ready_o}, 32'd0);
      if (stalled) begin
        check("stall_code_stable", {28'b0, code_o}, {28'b0, pc});
        check("stall_last_stable", {31'b0, code_last_o}, {31'b0, pl});
        check("stall_empty_stable", {31'b0, cur_empty()}, {31'b0, pe});
      end
      code_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (code_ready_i) begin
        got_code.push_back(int'(code_o));
        got_last.push_back(code_last_o);
        got_empty.push_back(cur_empty());
        done = code_last_o;
      end
      stalled = !code_ready_i;
      pc = code_o; pl = code_last_o; pe = cur_empty();
      // Garbage offered while busy must be ignored.
      vec_i = 16'($urandom);
      vec_valid_i = done ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
    end
    vec_valid_i = 1'b0;
    code_ready_i = 1'b0;
    check("idle_after_vector", {30'b0, vec_ready_o, code_valid_o}, 32'd2);
  endtask

  int exp_code[$];

  task automatic build_expected(input logic [15:0] v);
    exp_code.delete();
    for (int i = 0; i < 16; i++) if (v[i]) exp_code.push_back(i);
`ifdef MULTI_HIT_ENCODER_EMPTY_FLAG_EN
    if (v == 16'h0) exp_code.push_back(0);
`endif
  endtask

  task automatic compare_model(input logic [15:0] v);
    build_expected(v);
    check("beat_count", got_code.size(), exp_code.size());
    for (int i = 0; i < exp_code.size() && i < got_code.size(); i++) begin
      check("beat_code", got_code[i], exp_code[i]);
      check("beat_last", {31'b0, got_last[i]}, {31'b0, i == exp_code.size() - 1});
      check("beat_empty", {31'b0, got_empty[i]}, {31'b0, v == 16'h0});
    end
  endtask

  typedef struct {
    logic [15:0] vec;
    int          beats;
    int          first_code;
    int          last_code;
  } vec_rec_t;

  vec_rec_t tbl[6];

  initial begin
    tbl[0] = '{16'h8421, 4, 0, 15};
    tbl[1] = '{16'h0001, 1, 0, 0};
    tbl[2] = '{16'hFFFF, 16, 0, 15};
    tbl[3] = '{16'h8000, 1, 15, 15};
    tbl[4] = '{16'h0006, 2, 1, 2};
`ifdef MULTI_HIT_ENCODER_EMPTY_FLAG_EN
    tbl[5] = '{16'h0000, 1, 0, 0};
`else
    tbl[5] = '{16'h0000, 0, 0, 0};
`endif

    // Reset state
    tick(); tick();
    rst_i = 1'b0;
    check("rst_vec_ready", {31'b0, vec_ready_o}, 32'd1);
    check("rst_code_valid", {31'b0, code_valid_o}, 32'd0);
    check("rst_code_last", {31'b0, code_last_o}, 32'd0);
    check("rst_code", {28'b0, code_o}, 32'd0);
    check("rst_empty", {31'b0, cur_empty()}, 32'd0);

    // Table vectors at full ready: beat count equals EMIT cycles.
    foreach (tbl[t]) begin
      run_vec(tbl[t].vec, 1'b0);
      check("tbl_beats", got_code.size(), tbl[t].beats);
      check("tbl_emit_cycles", emit_cycles, tbl[t].beats);
      if (got_code.size() > 0) begin
        check("tbl_first_code", got_code[0], tbl[t].first_code);
        check("tbl_last_code", got_code[got_code.size()-1], tbl[t].last_code);
      end
      compare_model(tbl[t].vec);
    end

    // Backpressure: 0x0006 with ready low for three cycles.
    vec_i = 16'h0006; vec_valid_i = 1'b1; code_ready_i = 1'b0;
    tick();
    vec_valid_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("bp_valid", {31'b0, code_valid_o}, 32'd1);
      check("bp_code_hold", {28'b0, code_o}, 32'd1);
      check("bp_last_hold", {31'b0, code_last_o}, 32'd0);
      tick();
    end
    code_ready_i = 1'b1;
    check("bp_beat1", {28'b0, code_o}, 32'd1);
    tick();
    check("bp_beat2_code", {28'b0, code_o}, 32'd2);
    check("bp_beat2_last", {31'b0, code_last_o}, 32'd1);
    tick();
    code_ready_i = 1'b0;
    check("bp_idle", {30'b0, vec_ready_o, code_valid_o}, 32'd2);

    // Reset in the middle of 0x00F0 after beats 4 and 5.
    vec_i = 16'h00F0; vec_valid_i = 1'b1; code_ready_i = 1'b1;
    tick();
    vec_valid_i = 1'b0;
    check("rm_code4", {28'b0, code_o}, 32'd4);
    tick();
    check("rm_code5", {28'b0, code_o}, 32'd5);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rm_valid_low", {31'b0, code_valid_o}, 32'd0);
    check("rm_ready_high", {31'b0, vec_ready_o}, 32'd1);
    check("rm_code_zero", {28'b0, code_o}, 32'd0);
    for (int s = 0; s < 4; s++) begin
      check("rm_no_more_beats", {31'b0, code_valid_o}, 32'd0);
      tick();
    end
    code_ready_i = 1'b0;

    // Random vectors and random backpressure against the model.
    for (int r = 0; r < 40; r++) begin
      logic [15:0] v;
      case (r % 4)
        0: v = 16'($urandom);
        1: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2: v = 16'(1) << $urandom_range(0, 15);
        default: v = (r == 7) ? 16'h0 : 16'($urandom) | 16'h8000;
      endcase
      run_vec(v, 1'b1);
      compare_model(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/multi_hit_encoder.md
MULTI_HIT_ENCODER -- requirements
Module: multi_hit_encoder

Interface
REQ-001 SHALL have parameter CODE_WIDTH, default 4: width of each emitted index; input vector width is 2**CODE_WIDTH.
REQ-002 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port vec_i  input  2**CODE_WIDTH  hit vector; bit i set means index i is to be emitted.
REQ-005 SHALL have port vec_valid_i  input  1  vec_i is valid.
REQ-006 SHALL have port vec_ready_o  output  1  block can accept a vector.
REQ-007 SHALL have port code_o  output  CODE_WIDTH  binary index of the current hit.
REQ-008 SHALL have port code_valid_o  output  1  code_o is valid.
REQ-009 SHALL have port code_ready_i  input  1  downstream accepts code_o.
REQ-010 SHALL have port code_last_o  output  1  the current beat is the final hit of the vector.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and EMIT.
REQ-012 In IDLE: vec_ready_o=1 and code_valid_o=0.
REQ-013 In EMIT: vec_ready_o=0 and code_valid_o=1.
REQ-014 Input handshake: the vector is accepted on the edge where vec_valid_i && vec_ready_o. The non-zero vector is latched into a pending register and the FSM enters EMIT.
REQ-015 First code_valid_o SHALL occur in the cycle after acceptance (1-cycle latency).
REQ-016 code_o SHALL equal the index of the lowest set bit of the pending register.
REQ-017 code_last_o SHALL be 1 exactly when the pending register has one bit set.
REQ-018 code_o, code_valid_o and code_last_o SHALL depend only on registered state, with no combinational path from any input.
REQ-019 Output beat: occurs when code_valid_o && code_ready_i. On a beat, the lowest set pending bit is cleared. If the beat is last, the FSM returns to IDLE on that edge.
REQ-020 Backpressure: while code_valid_o && !code_ready_i, code_o and code_last_o SHALL hold stable.
REQ-021 Hits SHALL be emitted strictly in ascending index order, one per beat, no duplicates or omissions.
REQ-022 Throughput: a vector with k set bits occupies k EMIT cycles under full ready. The next vector is accepted no earlier than the cycle after the last beat.
REQ-023 vec_i SHALL be ignored while vec_ready_o=0.
REQ-024 An all-zero vector accepted in IDLE: handling per REQ-029/REQ-030.

Reset
REQ-025 While rst_i=1 on a clock edge: FSM to IDLE, pending register cleared.
REQ-026 After reset: vec_ready_o=1, code_valid_o=0, code_last_o=0, code_o=0.
REQ-027 Reset asserted during EMIT SHALL discard all remaining hits. code_valid_o SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-028 Macro MULTI_HIT_ENCODER_EMPTY_FLAG_EN SHALL select zero-vector handling.
REQ-029 Macro undefined: an accepted all-zero vector is dropped. No output beat; the FSM stays in IDLE; no empty_o port exists.
REQ-030 Macro defined: adds port empty_o (output, 1 bit). An accepted all-zero vector produces exactly one beat: code_o=0, code_last_o=1, empty_o=1.
REQ-031 Macro defined: empty_o is 0 on all other beats, 0 after reset, and obeys REQ-020 stability.

Verification (CODE_WIDTH=4)
REQ-032 vec_i=0x8421, code_ready_i=1:
- codes 0,5,10,15 on 4 consecutive cycles, code_last_o only on 15;
- vec_ready_o low for those 4 cycles, high afterwards.
REQ-033 vec_i=0x0001: single beat with code 0, code_last_o=1; back to IDLE on the next cycle.
REQ-034 vec_i=0x0006, code_ready_i held low 3 cycles then high:
- code_o=1 stable through the stall;
- beats 1 then 2, last on 2.
REQ-035 vec_i=0xFFFF, code_ready_i=1: 16 beats with codes 0..15, code_last_o only on 15.
REQ-036 vec_i=0x00F0, rst_i asserted after beats 4,5:
- next cycle code_valid_o=0, vec_ready_o=1;
- codes 6 and 7 never appear.
REQ-037 vec_i=0x0000:
- macro undefined: no beat, vec_ready_o stays 1;
- macro defined: one beat with code 0, code_last_o=1, empty_o=1.
